// File: rtl/vga_tile_fetch_arbiter.sv
// Tile-colour RAM arbiter: display fetches own fixed slots from hpos/vpos, and a
// one-entry host write buffer drains into the cycles left over.
module vga_tile_fetch_arbiter #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_TOTAL       = 800,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_TOTAL       = 525,
  parameter int unsigned COLS          = 80,
  parameter int unsigned ROWS          = 60,
  parameter int unsigned ADDR_W        = 13,
  parameter bit          WR_BLANK_ONLY = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [9:0]        hpos_i,
  input  logic [9:0]        vpos_i,
  input  logic              display_on_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [5:0]        wr_data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [5:0]        mem_wdata_o,
  input  logic [5:0]        mem_rdata_i,
  output logic [5:0]        rgb_o,
  output logic              frame_start_o
);

  localparam logic [9:0]        H_PRE    = 10'(H_TOTAL - 2);
  localparam logic [9:0]        MID_LAST = 10'(H_ACTIVE - 10);
  localparam logic [9:0]        V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CELLS    = ADDR_W'(COLS * ROWS);

  typedef enum logic {EMPTY, PENDING} wst_e;

  wst_e              state_q, state_d;
  logic [ADDR_W-1:0] held_addr_q, held_addr_d;
  logic [5:0]        held_data_q, held_data_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [5:0]        cur_color_q;
  logic              fetch_d1_q;
  logic              frame_start_q;

  logic [9:0]        nv;
  logic [10:0]       hp2;
  logic              mid_slot, pre_slot, fetch;
  logic [ADDR_W-1:0] fetch_addr;
  logic              free_cyc, accept, issue;

  // Fetch slots: the cell two pixels ahead mid-line, and column 0 of the next line
  // just before the line wraps.
  always_comb begin
    nv       = (vpos_i == V_LAST) ? 10'd0 : vpos_i + 10'd1;
    hp2      = {1'b0, hpos_i} + 11'd2;
    mid_slot = (vpos_i < V_ACT) && (hpos_i[2:0] == 3'd6) &&
               (hpos_i >= 10'd6) && (hpos_i <= MID_LAST);
    pre_slot = (hpos_i == H_PRE) && (nv < V_ACT);
    fetch    = mid_slot | pre_slot;
    if (pre_slot) fetch_addr = ADDR_W'(nv[9:3]) * COLS_A;
    else          fetch_addr = ADDR_W'(vpos_i[9:3]) * COLS_A + ADDR_W'(hp2[10:3]);
  end

  assign free_cyc = !fetch && (!WR_BLANK_ONLY || !display_on_i);

  // Write FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      held_addr_q <= '0;
      held_data_q <= '0;
    end else begin
      state_q     <= state_d;
      held_addr_q <= held_addr_d;
      held_data_q <= held_data_d;
    end
  end

  // Write FSM: next state
  always_comb begin
    state_d     = state_q;
    held_addr_d = held_addr_q;
    held_data_d = held_data_q;
    case (state_q)
      EMPTY: if (wr_valid_i) begin
        state_d     = PENDING;
        held_addr_d = wr_addr_i;
        held_data_d = wr_data_i;
      end
      PENDING: if (free_cyc) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    wr_ready_o = 1'b0;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state_q)
      EMPTY: begin
        wr_ready_o = 1'b1;
        accept     = wr_valid_i;
      end
      PENDING: issue = free_cyc;
      default: ;
    endcase
  end

  // Out-of-range addresses still consume the slot, they just never raise we.
  always_comb begin
    mem_we_o    = issue && (held_addr_q < CELLS);
    mem_wdata_o = held_data_q;
    if (fetch)      mem_addr_o = fetch_addr;
    else if (issue) mem_addr_o = held_addr_q;
    else            mem_addr_o = last_addr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_d1_q    <= 1'b0;
      cur_color_q   <= '0;
      last_addr_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      fetch_d1_q    <= fetch;
      if (fetch_d1_q) cur_color_q <= mem_rdata_i;
      if (fetch)      last_addr_q <= fetch_addr;
      frame_start_q <= (hpos_i == 10'd0) && (vpos_i == 10'd0);
    end
  end

  assign rgb_o         = display_on_i ? cur_color_q : 6'd0;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_tile_fetch_arbiter.sv
// Bench for vga_tile_fetch_arbiter: both WR_BLANK_ONLY variants share stimulus and
// are checked every cycle against a slot/queue-level reference model.
module tb_vga_tile_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hpos, vpos;
  logic        display_on;
  logic        wr_valid;
  logic [12:0] wr_addr;
  logic [5:0]  wr_data;
  logic [5:0]  mem_rdata;

  logic [1:0]  wr_ready, mem_we, frame_start;
  logic [12:0] mem_addr [2];
  logic [5:0]  mem_wdata [2];
  logic [5:0]  rgb [2];

  int vectors = 0;
  int errs    = 0;

  // reference model state
  int m_cur, m_last;
  bit m_pf, m_fs;
  bit m_pend [2];
  int m_ha [2], m_hd [2];

  always #5 clk = ~clk;

  vga_tile_fetch_arbiter #(.WR_BLANK_ONLY(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .hpos_i(hpos), .vpos_i(vpos), .display_on_i(display_on),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[0]), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .mem_addr_o(mem_addr[0]), .mem_we_o(mem_we[0]), .mem_wdata_o(mem_wdata[0]),
    .mem_rdata_i(mem_rdata), .rgb_o(rgb[0]), .frame_start_o(frame_start[0]));

  vga_tile_fetch_arbiter #(.WR_BLANK_ONLY(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .hpos_i(hpos), .vpos_i(vpos), .display_on_i(display_on),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[1]), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .mem_addr_o(mem_addr[1]), .mem_we_o(mem_we[1]), .mem_wdata_o(mem_wdata[1]),
    .mem_rdata_i(mem_rdata), .rgb_o(rgb[1]), .frame_start_o(frame_start[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h (h=%0d v=%0d)", tag, obs, exp, hpos, vpos);
    end
  endtask

  // Which RAM slot the display owns at (h,v), straight from the slot rules.
  function automatic void fetch_ref(input int h, input int v, output bit f, output int a);
    int nv;
    f = 1'b0;
    a = 0;
    if (v < 480 && h % 8 == 6 && h >= 6 && h <= 630) begin
      f = 1'b1;
      a = (v / 8) * 80 + (h + 2) / 8;
    end else if (h == 798) begin
      nv = (v == 524) ? 0 : v + 1;
      if (nv < 480) begin
        f = 1'b1;
        a = (nv / 8) * 80;
      end
    end
  endfunction

  function automatic bit disp_ref(input int h, input int v);
    return (h < 640) && (v < 480);
  endfunction

  task automatic model_reset();
    m_cur = 0; m_last = 0; m_pf = 1'b0; m_fs = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_pend[b] = 1'b0; m_ha[b] = 0; m_hd[b] = 0;
    end
  endtask

  task automatic settle();
    display_on = disp_ref(int'(hpos), int'(vpos));
    #2;
  endtask

  task automatic mchk();
    bit f, d, iss;
    int a, ea;
    fetch_ref(int'(hpos), int'(vpos), f, a);
    d = disp_ref(int'(hpos), int'(vpos));
    for (int b = 0; b < 2; b++) begin
      iss = m_pend[b] && !f && (b == 0 || !d);
      ea  = f ? a : (iss ? m_ha[b] : m_last);
      chk($sformatf("wr_ready%0d", b), 32'(wr_ready[b]), 32'(!m_pend[b]));
      chk($sformatf("mem_we%0d", b), 32'(mem_we[b]), 32'(iss && m_ha[b] < 4800));
      chk($sformatf("mem_addr%0d", b), 32'(mem_addr[b]), ea);
      chk($sformatf("mem_wdata%0d", b), 32'(mem_wdata[b]), m_hd[b]);
      chk($sformatf("rgb%0d", b), 32'(rgb[b]), d ? m_cur : 0);
      chk($sformatf("frame_start%0d", b), 32'(frame_start[b]), 32'(m_fs));
    end
  endtask

  task automatic tick();
    bit f, d;
    int a;
    bit iss [2];
    fetch_ref(int'(hpos), int'(vpos), f, a);
    d = disp_ref(int'(hpos), int'(vpos));
    for (int b = 0; b < 2; b++) iss[b] = m_pend[b] && !f && (b == 0 || !d);
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (m_pf) m_cur = int'(mem_rdata);
      m_pf = f;
      if (f) m_last = a;
      m_fs = (hpos == 10'd0) && (vpos == 10'd0);
      for (int b = 0; b < 2; b++) begin
        if (!m_pend[b]) begin
          if (wr_valid) begin
            m_pend[b] = 1'b1; m_ha[b] = int'(wr_addr); m_hd[b] = int'(wr_data);
          end
        end else if (iss[b]) m_pend[b] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle(); mchk(); tick();
  endtask

  task automatic pos(input int h, input int v);
    hpos = 10'(h); vpos = 10'(v);
  endtask

  initial begin
    int h, v, cnt, at;
    rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 13'd3; wr_data = 6'h33; mem_rdata = 6'h0;
    pos(6, 0);
    model_reset();
    @(posedge clk); #1;

    // reset held with a request pending on the input
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_wr_ready", 32'(wr_ready), 32'h3);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_fs", 32'(frame_start), 32'h0);
      mchk(); tick();
    end
    settle();
    rst_n = 1'b1;
    #1;
    chk("rel_wr_ready", 32'(wr_ready), 32'h3);
    mchk(); tick();
    wr_valid = 1'b0;
    for (int i = 7; i < 12; i++) begin pos(i, 0); cyc(); end

    // mid-line fetch
    pos(6, 8); settle();
    chk("mid_addr", 32'(mem_addr[0]), 32'd81);
    chk("mid_we", 32'(mem_we[0]), 32'd0);
    mchk(); tick();
    pos(7, 8); mem_rdata = 6'h2A; cyc();
    for (int i = 8; i < 16; i++) begin
      pos(i, 8); mem_rdata = 6'($urandom); settle();
      chk("mid_rgb", 32'(rgb[0]), 32'h2A);
      mchk(); tick();
    end

    // line-start prefetch
    pos(798, 15); settle(); chk("pre_addr15", 32'(mem_addr[0]), 32'd160); mchk(); tick();
    pos(799, 15); cyc();
    pos(798, 524); settle(); chk("pre_addr524", 32'(mem_addr[0]), 32'd0); mchk(); tick();
    pos(799, 524); cyc();
    pos(798, 479); mem_rdata = 6'h11; cyc();
    pos(799, 479); mem_rdata = 6'h22; cyc();
    pos(0, 0); cyc();

    // write colliding with a fetch slot
    pos(5, 0); wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 6'h15; cyc();
    wr_valid = 1'b0; wr_addr = 13'h1FFF; wr_data = 6'h3F;
    pos(6, 0); settle();
    chk("col_we6", 32'(mem_we[0]), 32'd0);
    chk("col_addr6", 32'(mem_addr[0]), 32'd1);
    mchk(); tick();
    pos(7, 0); settle();
    chk("col_we7", 32'(mem_we[0]), 32'd1);
    chk("col_addr7", 32'(mem_addr[0]), 32'd5);
    chk("col_wdata7", 32'(mem_wdata[0]), 32'h15);
    mchk(); tick();
    pos(8, 0); settle(); chk("col_ready8", 32'(wr_ready[0]), 32'd1); mchk(); tick();
    for (int i = 700; i < 703; i++) begin pos(i, 0); cyc(); end

    // blank-only drain
    cnt = 0; at = -1;
    pos(100, 10); wr_valid = 1'b1; wr_addr = 13'd900; wr_data = 6'h2C; cyc();
    wr_valid = 1'b0;
    for (int i = 101; i < 646; i++) begin
      pos(i, 10); settle();
      if (mem_we[1]) begin cnt++; at = i; end
      mchk(); tick();
    end
    chk("blank_pulses", cnt, 1);
    chk("blank_at", at, 640);

    // out-of-range address
    cnt = 0;
    pos(100, 500); wr_valid = 1'b1; wr_addr = 13'd4800; wr_data = 6'h01; cyc();
    wr_valid = 1'b0;
    pos(101, 500); settle(); cnt += int'(mem_we[0]) + int'(mem_we[1]); mchk(); tick();
    pos(102, 500); settle();
    chk("oor_ready", 32'(wr_ready), 32'h3);
    cnt += int'(mem_we[0]) + int'(mem_we[1]); mchk(); tick();
    chk("oor_we", cnt, 0);

    // frame boundary
    cnt = 0;
    for (int i = 790; i < 806; i++) begin
      if (i < 800) pos(i, 524); else pos(i - 800, 0);
      settle(); cnt += int'(frame_start[0]); mchk(); tick();
    end
    chk("fs_pulses", cnt, 1);

    // randomized scan segments
    for (int s = 0; s < 5; s++) begin
      if (s == 0) begin h = 400; v = 524; end
      else begin h = int'($urandom_range(0, 799)); v = int'($urandom_range(0, 524)); end
      for (int i = 0; i < 1200; i++) begin
        pos(h, v);
        wr_valid  = ($urandom_range(0, 2) == 0);
        wr_addr   = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(4800, 8191))
                                                : 13'($urandom_range(0, 4799));
        wr_data   = 6'($urandom);
        mem_rdata = 6'($urandom);
        cyc();
        h++;
        if (h == 800) begin h = 0; v = (v == 524) ? 0 : v + 1; end
      end
    end

    // reset in the middle of a pending blank-only write
    pos(100, 20); wr_valid = 1'b1; wr_addr = 13'd10; wr_data = 6'h07; cyc();
    wr_valid = 1'b0;
    pos(101, 20); settle();
    rst_n = 1'b0; model_reset(); #1;
    chk("mrst_we", 32'(mem_we), 32'h0);
    chk("mrst_rgb", 32'(rgb[1]), 32'h0);
    mchk(); tick();
    pos(102, 20); settle(); rst_n = 1'b1; #1; mchk(); tick();
    for (int i = 103; i < 130; i++) begin
      pos(i, 20); mem_rdata = 6'($urandom); cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
